// File: rtl/tdm_demux_1x4_if.sv
// Serial sample input and frame-coherent parallel channel outputs
// of the 1-to-4 TDM demultiplexer.
interface tdm_demux_1x4_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_sync;
    logic              err_clr;
    logic [DATA_W-1:0] out0;
    logic [DATA_W-1:0] out1;
    logic [DATA_W-1:0] out2;
    logic [DATA_W-1:0] out3;
    logic              frame_valid;
    logic              locked;
    logic [1:0]        slot;
    logic              sync_err;

    modport master (
        output in_valid, in_data, in_sync, err_clr,
        input  out0, out1, out2, out3, frame_valid, locked, slot, sync_err
    );

    modport slave (
        input  in_valid, in_data, in_sync, err_clr,
        output out0, out1, out2, out3, frame_valid, locked, slot, sync_err
    );
endinterface

// File: rtl/tdm_demux_1x4.sv
// Frame-aligned 1-to-4 TDM demultiplexer: slots 0..2 are staged in shadow
// registers and the whole frame is published together on the slot-3 sample.
module tdm_demux_1x4 #(
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    tdm_demux_1x4_if.slave  bus
);
    typedef enum logic {HUNT, LOCKED} state_t;

    state_t                 r_state;
    logic [1:0]             r_slot;
    logic [2:0][DATA_W-1:0] r_shadow;
    logic [3:0][DATA_W-1:0] r_out;
    logic                   r_frame_valid;
    logic                   r_locked;
    logic                   r_sync_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_slot        <= 2'd0;
            r_shadow      <= '0;
            r_out         <= '0;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            // Any error set below overrides this clear.
            if (bus.err_clr)
                r_sync_err <= 1'b0;
            if (bus.in_valid) begin
                case (r_state)
                    HUNT: begin
                        if (bus.in_sync) begin
                            r_shadow[0] <= bus.in_data;
                            r_slot      <= 2'd1;
                            r_state     <= LOCKED;
                            r_locked    <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (r_slot == 2'd0) begin
                            if (bus.in_sync) begin
                                r_shadow[0] <= bus.in_data;
                                r_slot      <= 2'd1;
                            end else begin
                                r_sync_err <= 1'b1;
                                r_state    <= HUNT;
                                r_locked   <= 1'b0;
                                r_slot     <= 2'd0;
                            end
                        end else if (bus.in_sync) begin
                            // Early sync: drop the partial frame and realign in place.
                            r_sync_err  <= 1'b1;
                            r_shadow[0] <= bus.in_data;
                            r_slot      <= 2'd1;
                        end else begin
                            case (r_slot)
                                2'd1: r_shadow[1] <= bus.in_data;
                                2'd2: r_shadow[2] <= bus.in_data;
                                default: begin
                                    r_out         <= {bus.in_data, r_shadow[2],
                                                      r_shadow[1], r_shadow[0]};
                                    r_frame_valid <= 1'b1;
                                end
                            endcase
                            r_slot <= r_slot + 2'd1;
                        end
                    end
                    default: begin
                        r_state  <= HUNT;
                        r_locked <= 1'b0;
                        r_slot   <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign bus.out0        = r_out[0];
    assign bus.out1        = r_out[1];
    assign bus.out2        = r_out[2];
    assign bus.out3        = r_out[3];
    assign bus.frame_valid = r_frame_valid;
    assign bus.locked      = r_locked;
    assign bus.slot        = r_slot;
    assign bus.sync_err    = r_sync_err;
endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Frame-aligned 1-to-4 time-division demultiplexer, the receive-side counterpart of the 4:1 channel mux.
- Takes a serial sample stream where each frame is four consecutive valid samples (slot 0..3), with slot 0 flagged by `in_sync`.
- Distributes the samples onto four parallel channel outputs and publishes them frame-coherently.
- Sits at the output of a serialising link or mux chain to restore i0..i3 style parallel channels.

Parameters:
- DATA_W, 8, width of each sample and each channel output.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample present on in_data this cycle.
- in_data  input  DATA_W  sample value.
- in_sync  input  1  qualifies current valid sample as slot 0; ignored when in_valid=0.
- err_clr  input  1  synchronous clear of sync_err.
- out0  output  DATA_W  channel 0 (slot 0) of last complete frame.
- out1  output  DATA_W  channel 1 (slot 1) of last complete frame.
- out2  output  DATA_W  channel 2 (slot 2) of last complete frame.
- out3  output  DATA_W  channel 3 (slot 3) of last complete frame.
- frame_valid  output  1  one-cycle pulse when out0..out3 update.
- locked  output  1  high in LOCKED state.
- slot  output  2  slot index expected for the next valid sample (0 in HUNT).
- sync_err  output  1  sticky framing-error flag.

Behaviour:
- Reset (async assert, sync release):
  - out0..out3 = 0, frame_valid = 0, locked = 0, slot = 0, sync_err = 0.
  - Shadow registers = 0, state = HUNT.
- State HUNT:
  - Samples without in_sync are discarded; no shadow or output change.
  - in_valid & in_sync: in_data -> shadow0, slot <= 1, state <= LOCKED.
- State LOCKED, on each in_valid:
  - slot=1..3, in_sync=0: in_data -> shadow[slot], slot <= slot+1 (wraps 3->0).
  - slot=3 capture: next cycle out0..out2 <= shadow0..2, out3 <= that slot-3 sample, frame_valid = 1 for exactly that one cycle. Latency is 1 clk from the slot-3 sample edge to the outputs.
  - slot=0, in_sync=1: normal frame start; in_data -> shadow0, slot <= 1.
  - slot=0, in_sync=0 (missing sync): sample dropped, sync_err <= 1, state <= HUNT, slot <= 0.
  - slot=1..3, in_sync=1 (early sync): partial frame discarded with no frame_valid. sync_err <= 1, sample -> shadow0, slot <= 1, stay LOCKED (realign without HUNT).
- in_valid=0 cycles:
  - No state change in either state; gaps of any length within a frame are legal.
- Outputs:
  - out0..out3 hold their value between frame_valid pulses.
  - Outputs never show a mix of two frames.
- sync_err:
  - Set has priority over err_clr in the same cycle.
  - Otherwise err_clr clears it on the next edge.
- locked = (state==LOCKED), registered.
- Back-to-back frames with in_valid continuously high sustain 1 sample/clk. frame_valid pulses every 4th cycle with no bubble.
- Reset mid-frame:
  - Immediate return to reset values.
  - Partial frame lost; no frame_valid after release until a full new frame completes.

Test Plan:
- Reset then in_valid=1 continuous: sync on 0x11, then 0x22, 0x33, 0x44 -> one cycle after 0x44, out0..3 = 11,22,33,44, frame_valid pulse of 1 cycle, locked=1, sync_err=0.
- Samples 0xAA, 0xBB with no sync while in HUNT -> outputs stay 0, locked=0, slot=0. Then sync frame 01..04 -> out = 01,02,03,04.
- Frame 10,20,30,40 with in_valid low for 3 cycles between each sample -> identical result to the gapless case, single frame_valid.
- Locked; sync frame starts 55,66, then in_sync=1 on 0x77, then 88,99,AA -> no frame_valid for the 55/66 frame. sync_err=1, then out = 77,88,99,AA. Pulse err_clr -> sync_err=0.
- Locked after one good frame; next slot-0 sample 0xEE without sync -> dropped, sync_err=1, locked=0, out unchanged. Assert err_clr and in_valid&in_sync in the same cycle with no new error -> sync_err=0.
- rst_n pulsed low asynchronously (between edges) after 2 samples of a frame -> all outputs 0 immediately. After release, remaining 2 samples without sync produce nothing; next full sync frame decodes correctly.
